// File: rtl/debug_slave_pkg.sv
`default_nettype none
// ============================================================================
// debug_slave_pkg : shared types and constants for the JTAG debug slave
// Revision: 1.0
// ============================================================================
package debug_slave_pkg;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        DISPATCH = 1'b1
    } disp_state_e;

    localparam logic [1:0] IR_OCIMEM    = 2'd0;
    localparam logic [1:0] IR_TRACE     = 2'd1;
    localparam logic [1:0] IR_BREAK     = 2'd2;
    localparam logic [1:0] IR_TRACECTRL = 2'd3;

    localparam int DEF_DATA_W      = 38;
    localparam int DEF_IR_W        = 2;
    localparam int DEF_NUM_CH      = 4;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_TIMEOUT_CYC = 1024;

endpackage
`default_nettype wire

// File: rtl/debug_strobe_sync.sv
`default_nettype none
// ============================================================================
// debug_strobe_sync : multi-stage synchroniser with registered rising-edge pulse
// Revision: 1.0
// ============================================================================
module debug_strobe_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic strobe_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   delay_q;
    logic                   rise_q;

    // The pulse is registered so downstream logic sees a clean single-cycle flop output.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q  <= '0;
            delay_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], strobe_i};
            delay_q <= sync_q[SYNC_STAGES-1];
            rise_q  <= sync_q[SYNC_STAGES-1] & ~delay_q;
        end
    end

    assign rise_o = rise_q;

endmodule
`default_nettype wire

// File: rtl/debug_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// debug_cmd_dispatcher : routes captured JTAG commands to CPU debug channels
// Revision: 1.0
// ============================================================================
module debug_cmd_dispatcher
    import debug_slave_pkg::*;
#(
    parameter int  DATA_W      = DEF_DATA_W,
    parameter int  IR_W        = DEF_IR_W,
    parameter int  NUM_CH      = DEF_NUM_CH,
    parameter int  SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int  TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vs_uir,
    input  logic              vs_e1dr,
    input  logic [IR_W-1:0]   ir_in,
    input  logic [CH_W-1:0]   ch_sel,
    input  logic [DATA_W-1:0] sr,
    output logic [DATA_W-1:0] jdo,
    output logic [IR_W-1:0]   cmd_ir,
    output logic [NUM_CH-1:0] cmd_valid,
    input  logic [NUM_CH-1:0] cmd_ready,
    output logic              busy,
    output logic              overrun,
    output logic              timeout,
    output logic              bad_ch,
    input  logic              err_clr
);

    localparam int              TO_W    = $clog2(TIMEOUT_CYC);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic w_uir_edge;
    logic w_e1dr_edge;

    debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_uir_sync (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (vs_uir),
        .rise_o   (w_uir_edge)
    );

    debug_strobe_sync #(.SYNC_STAGES(SYNC_STAGES)) u_e1dr_sync (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (vs_e1dr),
        .rise_o   (w_e1dr_edge)
    );

    disp_state_e       state_q, state_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [CH_W-1:0]   ch_act_q, ch_act_d;
    logic [DATA_W-1:0] jdo_q, jdo_d;
    logic [IR_W-1:0]   cmd_ir_q, cmd_ir_d;
    logic [TO_W-1:0]   cnt_q, cnt_d;
    logic              overrun_q, overrun_d;
    logic              timeout_q, timeout_d;
    logic              bad_ch_q, bad_ch_d;

    logic [NUM_CH-1:0] w_valid;
    logic              w_busy;
    logic              w_ready_hit;
    logic              w_ch_ok;

    always_comb begin
        w_valid = '0;
        w_busy  = 1'b0;
        if (state_q == DISPATCH) begin
            w_busy = 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                w_valid[i] = (ch_act_q == CH_W'(i));
            end
        end
    end

    // Only the selected channel's ready can complete a transfer.
    assign w_ready_hit = |(cmd_ready & w_valid);
    assign w_ch_ok     = int'(ch_q) < NUM_CH;

    always_comb begin
        logic set_ovr;
        logic set_tmo;
        logic set_bad;

        state_d  = state_q;
        ir_d     = ir_q;
        ch_d     = ch_q;
        ch_act_d = ch_act_q;
        jdo_d    = jdo_q;
        cmd_ir_d = cmd_ir_q;
        cnt_d    = cnt_q;
        set_ovr  = 1'b0;
        set_tmo  = 1'b0;
        set_bad  = 1'b0;

        if (w_uir_edge) begin
            ir_d = ir_in;
            ch_d = ch_sel;
        end

        case (state_q)
            IDLE: begin
                if (w_e1dr_edge) begin
                    jdo_d    = sr;
                    cmd_ir_d = ir_q;
                    if (w_ch_ok) begin
                        ch_act_d = ch_q;
                        cnt_d    = '0;
                        state_d  = DISPATCH;
                    end else begin
                        set_bad = 1'b1;
                    end
                end
            end
            DISPATCH: begin
                cnt_d = cnt_q + 1'b1;
                if (w_e1dr_edge) begin
                    set_ovr = 1'b1;
                end
                // A ready in the final counted cycle still completes the transfer.
                if (w_ready_hit) begin
                    state_d = IDLE;
                end else if (cnt_q == TO_LAST) begin
                    set_tmo = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        overrun_d = set_ovr | (overrun_q & ~err_clr);
        timeout_d = set_tmo | (timeout_q & ~err_clr);
        bad_ch_d  = set_bad | (bad_ch_q & ~err_clr);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            ir_q      <= '0;
            ch_q      <= '0;
            ch_act_q  <= '0;
            jdo_q     <= '0;
            cmd_ir_q  <= '0;
            cnt_q     <= '0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
            bad_ch_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            ch_q      <= ch_d;
            ch_act_q  <= ch_act_d;
            jdo_q     <= jdo_d;
            cmd_ir_q  <= cmd_ir_d;
            cnt_q     <= cnt_d;
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            bad_ch_q  <= bad_ch_d;
        end
    end

    assign jdo       = jdo_q;
    assign cmd_ir    = cmd_ir_q;
    assign cmd_valid = w_valid;
    assign busy      = w_busy;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;
    assign bad_ch    = bad_ch_q;

endmodule
`default_nettype wire

// File: tb/tb_debug_cmd_dispatcher.sv
`default_nettype none
// ============================================================================
// tb_debug_cmd_dispatcher : directed and randomized checks against a command-level model
// Revision: 1.0
// ============================================================================
module tb_debug_cmd_dispatcher;

    localparam int DATA_W      = 38;
    localparam int IR_W        = 2;
    localparam int NUM_CH      = 3;
    localparam int CH_W        = 2;
    localparam int SYNC_STAGES = 2;
    localparam int TMO         = 16;
    localparam int LAT         = SYNC_STAGES + 2;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              vs_uir = 1'b0;
    logic              vs_e1dr = 1'b0;
    logic [IR_W-1:0]   ir_in = '0;
    logic [CH_W-1:0]   ch_sel = '0;
    logic [DATA_W-1:0] sr = '0;
    logic [DATA_W-1:0] jdo;
    logic [IR_W-1:0]   cmd_ir;
    logic [NUM_CH-1:0] cmd_valid;
    logic [NUM_CH-1:0] cmd_ready = '0;
    logic              busy;
    logic              overrun;
    logic              timeout;
    logic              bad_ch;
    logic              err_clr = 1'b0;

    debug_cmd_dispatcher #(
        .DATA_W      (DATA_W),
        .IR_W        (IR_W),
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .vs_uir    (vs_uir),
        .vs_e1dr   (vs_e1dr),
        .ir_in     (ir_in),
        .ch_sel    (ch_sel),
        .sr        (sr),
        .jdo       (jdo),
        .cmd_ir    (cmd_ir),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .busy      (busy),
        .overrun   (overrun),
        .timeout   (timeout),
        .bad_ch    (bad_ch),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] exp_jdo = '0;
    logic [IR_W-1:0]   exp_cir = '0;
    bit                exp_ovr = 1'b0;
    bit                exp_tmo = 1'b0;
    bit                exp_bad = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s @%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Advance one clock, apply the sticky-flag rules for this edge, compare all outputs.
    task automatic tick_check(input logic [NUM_CH-1:0] ev, input bit s_bad, input bit s_tmo,
                              input bit s_ovr);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_ovr = 1'b0;
            exp_tmo = 1'b0;
            exp_bad = 1'b0;
            exp_jdo = '0;
            exp_cir = '0;
        end else begin
            exp_ovr = s_ovr | (exp_ovr & ~err_clr);
            exp_tmo = s_tmo | (exp_tmo & ~err_clr);
            exp_bad = s_bad | (exp_bad & ~err_clr);
        end
        chk("cmd_valid", 64'(cmd_valid), 64'(ev));
        chk("busy",      64'(busy),      64'(|ev));
        chk("jdo",       64'(jdo),       64'(exp_jdo));
        chk("cmd_ir",    64'(cmd_ir),    64'(exp_cir));
        chk("overrun",   64'(overrun),   64'(exp_ovr));
        chk("timeout",   64'(timeout),   64'(exp_tmo));
        chk("bad_ch",    64'(bad_ch),    64'(exp_bad));
    endtask

    // One command: program IR/channel, raise exit1-DR, serve ready after d cycles of valid.
    task automatic run_cmd(input logic [IR_W-1:0] ir, input logic [CH_W-1:0] ch,
                           input logic [DATA_W-1:0] data, input int d, input bit ovr,
                           input int clr_at, input int rst_at);
        bit                good;
        bit                aborted;
        int                n;
        int                t_end;
        logic [NUM_CH-1:0] onehot;
        logic [NUM_CH-1:0] ev;

        good   = int'(ch) < NUM_CH;
        n      = (d < TMO) ? d + 1 : TMO;
        onehot = good ? (NUM_CH'(1) << ch) : '0;

        ir_in  = ir;
        ch_sel = ch;
        vs_uir = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick_check('0, 1'b0, 1'b0, 1'b0);
            if (k == 1) vs_uir = 1'b0;
        end

        sr      = data;
        vs_e1dr = 1'b1;
        t_end   = good ? LAT + n + 8 : LAT + 8;
        for (int t = 1; t <= t_end; t++) begin
            aborted = (rst_at >= 0) && (t > rst_at);
            ev = (good && !aborted && t >= LAT && t <= LAT + n - 1) ? onehot : '0;
            if (t == LAT && !aborted) begin
                exp_jdo = data;
                exp_cir = ir;
            end
            tick_check(ev, !good && !aborted && t == LAT,
                       good && !aborted && d >= TMO && t == LAT + TMO,
                       ovr && !aborted && t == 2 * LAT);

            cmd_ready = NUM_CH'($urandom);
            if (good && t >= LAT) cmd_ready[ch] = (t >= LAT + d);
            if (t == 2) vs_e1dr = 1'b0;
            if (ovr && t == LAT) begin
                sr      = DATA_W'(1);
                vs_e1dr = 1'b1;
            end
            if (ovr && t == LAT + 2) vs_e1dr = 1'b0;
            if (good && t == LAT) begin
                ir_in  = IR_W'($urandom);
                ch_sel = CH_W'($urandom);
                vs_uir = 1'b1;
            end
            if (t == LAT + 2) vs_uir = 1'b0;
            err_clr = (t == clr_at);
            reset   = (t == rst_at);
        end
        err_clr   = 1'b0;
        reset     = 1'b0;
        cmd_ready = '0;
    endtask

    initial begin
        logic [DATA_W-1:0] data;
        logic [CH_W-1:0]   ch;
        int                d;
        bit                ovr;
        int                clr_at;

        for (int k = 0; k < 3; k++) tick_check('0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick_check('0, 1'b0, 1'b0, 1'b0);

        // basic transfer, ready held from the first valid cycle
        run_cmd(2'd2, 2'd1, 38'h2A_DEAD_BEEF, 0, 1'b0, -1, -1);
        // ready delayed by 7 cycles
        run_cmd(2'd1, 2'd1, DATA_W'({$urandom, $urandom}), 7, 1'b0, -1, -1);
        // timeout, then cleared
        run_cmd(2'd3, 2'd0, DATA_W'({$urandom, $urandom}), 16, 1'b0, LAT + TMO + 4, -1);
        // timeout set in the same cycle as err_clr
        run_cmd(2'd0, 2'd2, DATA_W'({$urandom, $urandom}), 20, 1'b0, LAT + TMO - 1, -1);
        // overrun while dispatching
        run_cmd(2'd2, 2'd1, 38'h01_2345_6789, 8, 1'b1, -1, -1);
        // channel out of range
        run_cmd(2'd1, 2'd3, DATA_W'({$urandom, $urandom}), 0, 1'b0, -1, -1);
        // reset mid-dispatch, followed by a normal command
        run_cmd(2'd2, 2'd2, DATA_W'({$urandom, $urandom}), 20, 1'b0, -1, 8);
        run_cmd(2'd3, 2'd0, DATA_W'({$urandom, $urandom}), 2, 1'b0, -1, -1);

        for (int i = 0; i < 40; i++) begin
            data   = DATA_W'({$urandom, $urandom});
            ch     = CH_W'($urandom_range(0, 3));
            d      = $urandom_range(0, 20);
            ovr    = (int'(ch) < NUM_CH) && (d >= 3) && ($urandom_range(0, 2) == 0);
            clr_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 28)) : -1;
            run_cmd(IR_W'($urandom), ch, data, d, ovr, clr_at, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
